// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared widths and FSM encodings for the activation loop sequencer
package act_pkg;

   // Default counter widths and skip counts
   localparam int ROW_W_DEF     = 5;
   localparam int BLK_W_DEF     = 4;
   localparam int FRM_W_DEF     = 4;
   localparam int PAT_W_DEF     = 4;
   localparam int GRP_W_DEF     = 4;
   localparam int COL_SKIP_DEF  = 2;
   localparam int PSUM_SKIP_DEF = 2;

   // Sequencer FSM encoding
   typedef logic [1:0] act_state_t;
   localparam act_state_t ST_IDLE = 2'd0;
   localparam act_state_t ST_RUN  = 2'd1;
   localparam act_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/act_loop_cnt.sv
// rtl/act_loop_cnt.sv - width-parametrised wrap counter for one loop level
import act_pkg::*;

module act_loop_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clear,
   input  logic [W-1:0] max,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   // wrap flags that the count sits at its terminal value; the next enable returns it to 0
   assign wrap = (cnt == max);

   // Count up on enable, wrapping at max; clear has priority over counting
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/act_loop_ctrl.sv
// rtl/act_loop_ctrl.sv - activation-fetch loop sequencer with start/abort/done FSM
import act_pkg::*;

module act_loop_ctrl #(
   parameter int ROW_W     = ROW_W_DEF,
   parameter int BLK_W     = BLK_W_DEF,
   parameter int FRM_W     = FRM_W_DEF,
   parameter int PAT_W     = PAT_W_DEF,
   parameter int GRP_W     = GRP_W_DEF,
   parameter int COL_SKIP  = COL_SKIP_DEF,
   parameter int PSUM_SKIP = PSUM_SKIP_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [ROW_W-1:0] cfg_len_row,
   input  logic [BLK_W-1:0] cfg_num_blk,
   input  logic [FRM_W-1:0] cfg_num_frm,
   input  logic [PAT_W-1:0] cfg_num_pat,
   input  logic [GRP_W-1:0] cfg_num_grp,
   input  logic             cfg_pat_inner,
   output logic             fetch_vld,
   input  logic             fetch_rdy,
   output logic             frt_act_row,
   output logic             lst_act_row,
   output logic             lst_act_blk,
   output logic             frt_blk,
   output logic             val_col,
   output logic             val_psum,
   output logic             even_frm,
   output logic             pool_en,
   output logic [PAT_W-1:0] cnt_pat,
   output logic [GRP_W-1:0] cnt_grp,
   output logic             nxt_pat,
   output logic             nxt_grp,
   output logic             rst_ifm,
   output logic             rst_ftr,
   output logic             busy,
   output logic             done
);

   act_state_t       state;
   logic [ROW_W-1:0] len_row_q;
   logic [BLK_W-1:0] num_blk_q;
   logic [FRM_W-1:0] num_frm_q;
   logic [PAT_W-1:0] num_pat_q;
   logic [GRP_W-1:0] num_grp_q;
   logic             pat_inner_q;

   logic [ROW_W-1:0] cnt_act, cnt_row;
   logic [BLK_W-1:0] cnt_blk;
   logic [FRM_W-1:0] cnt_frm;
   logic             act_at, row_at, blk_at, frm_at, pat_at, grp_at;

   logic run, beat, start_acc, cnt_clear;
   logic row_en, blk_en, frm_en, step, pat_en, grp_en, layer_end;
   logic pat_inc, grp_inc;

   assign run       = (state == ST_RUN);
   assign fetch_vld = run;
   assign busy      = run;
   assign beat      = run & fetch_rdy;
   assign start_acc = start & ~abort & ((state == ST_IDLE) | (state == ST_DONE));
   assign cnt_clear = abort | ~run;

   // Loop nest enables: each level advances when every inner level is at its maximum
   assign row_en    = beat & act_at;
   assign blk_en    = row_en & row_at;
   assign frm_en    = blk_en & blk_at;
   assign step      = frm_en & frm_at;
   assign pat_en    = step & (pat_inner_q | grp_at);
   assign grp_en    = step & (~pat_inner_q | pat_at);
   assign layer_end = step & pat_at & grp_at;

   // A wrap to 0 is announced by the outer loop's pulse, so only increments pulse here;
   // on the final beat both counters are at max, so neither pulses
   assign pat_inc   = pat_en & ~pat_at;
   assign grp_inc   = grp_en & ~grp_at;

   act_loop_cnt #(.W(ROW_W)) u_act (.clk(clk), .rst_n(rst_n), .en(beat),   .clear(cnt_clear), .max(len_row_q), .cnt(cnt_act), .wrap(act_at));
   act_loop_cnt #(.W(ROW_W)) u_row (.clk(clk), .rst_n(rst_n), .en(row_en), .clear(cnt_clear), .max(len_row_q), .cnt(cnt_row), .wrap(row_at));
   act_loop_cnt #(.W(BLK_W)) u_blk (.clk(clk), .rst_n(rst_n), .en(blk_en), .clear(cnt_clear), .max(num_blk_q), .cnt(cnt_blk), .wrap(blk_at));
   act_loop_cnt #(.W(FRM_W)) u_frm (.clk(clk), .rst_n(rst_n), .en(frm_en), .clear(cnt_clear), .max(num_frm_q), .cnt(cnt_frm), .wrap(frm_at));
   act_loop_cnt #(.W(PAT_W)) u_pat (.clk(clk), .rst_n(rst_n), .en(pat_en), .clear(cnt_clear), .max(num_pat_q), .cnt(cnt_pat), .wrap(pat_at));
   act_loop_cnt #(.W(GRP_W)) u_grp (.clk(clk), .rst_n(rst_n), .en(grp_en), .clear(cnt_clear), .max(num_grp_q), .cnt(cnt_grp), .wrap(grp_at));

   // Position and qualifier flags describe the act offered this cycle
   assign frt_act_row = run & (cnt_act == '0);
   assign lst_act_row = run & act_at;
   assign lst_act_blk = run & act_at & row_at;
   assign frt_blk     = run & (cnt_blk == '0);
   assign val_col     = run & (cnt_act >= ROW_W'(COL_SKIP));
   assign val_psum    = run & (cnt_row >= ROW_W'(PSUM_SKIP));
   assign even_frm    = run & ~cnt_frm[0];
   assign pool_en     = run & (cnt_blk != '0) & (cnt_frm != '0) & (cnt_act == '0) & (cnt_row == '0);

   // FSM: abort wins over everything, start only accepted from IDLE or DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) state <= ST_RUN;
            ST_RUN:  if (layer_end) state <= ST_DONE;
            ST_DONE: state <= start ? ST_RUN : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Shadow configuration captured on an accepted start so mid-run edits are invisible
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_row_q   <= '0;
         num_blk_q   <= '0;
         num_frm_q   <= '0;
         num_pat_q   <= '0;
         num_grp_q   <= '0;
         pat_inner_q <= 1'b0;
      end else if (start_acc) begin
         len_row_q   <= cfg_len_row;
         num_blk_q   <= cfg_num_blk;
         num_frm_q   <= cfg_num_frm;
         num_pat_q   <= cfg_num_pat;
         num_grp_q   <= cfg_num_grp;
         pat_inner_q <= cfg_pat_inner;
      end
   end

   // Registered one-cycle pulses following the step-ending beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nxt_pat <= 1'b0;
         nxt_grp <= 1'b0;
         rst_ifm <= 1'b0;
         rst_ftr <= 1'b0;
         done    <= 1'b0;
      end else begin
         nxt_pat <= pat_inc & ~abort;
         nxt_grp <= grp_inc & ~abort;
         rst_ifm <= grp_inc & ~abort & pat_inner_q;
         rst_ftr <= pat_inc & ~abort & ~pat_inner_q;
         done    <= layer_end & ~abort;
      end
   end

endmodule

// File: tb/tb_act_loop_ctrl.sv
// tb/tb_act_loop_ctrl.sv - scoreboard bench for act_loop_ctrl
module tb_act_loop_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, cfg_pat_inner, fetch_rdy;
   logic [4:0] cfg_len_row;
   logic [3:0] cfg_num_blk, cfg_num_frm, cfg_num_pat, cfg_num_grp;
   logic       fetch_vld, frt_act_row, lst_act_row, lst_act_blk, frt_blk;
   logic       val_col, val_psum, even_frm, pool_en;
   logic [3:0] cnt_pat, cnt_grp;
   logic       nxt_pat, nxt_grp, rst_ifm, rst_ftr, busy, done;

   always #5 clk = ~clk;

   act_loop_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_len_row(cfg_len_row), .cfg_num_blk(cfg_num_blk), .cfg_num_frm(cfg_num_frm),
      .cfg_num_pat(cfg_num_pat), .cfg_num_grp(cfg_num_grp), .cfg_pat_inner(cfg_pat_inner),
      .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
      .frt_act_row(frt_act_row), .lst_act_row(lst_act_row), .lst_act_blk(lst_act_blk), .frt_blk(frt_blk),
      .val_col(val_col), .val_psum(val_psum), .even_frm(even_frm), .pool_en(pool_en),
      .cnt_pat(cnt_pat), .cnt_grp(cnt_grp),
      .nxt_pat(nxt_pat), .nxt_grp(nxt_grp), .rst_ifm(rst_ifm), .rst_ftr(rst_ftr),
      .busy(busy), .done(done)
   );

   typedef struct {
      int beats; int frt; int lab_n; int lab_sum;
      int nxt_pat; int nxt_grp; int rst_ifm; int rst_ftr;
      int pool; int vcol; int vpsum; int even;
   } exp_t;

   exp_t sb[$];
   exp_t acc;
   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;
   int   since_beat = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int beats, frt, lab_n, lab_sum, np, ng, ri, rf, pool, vc, vp, ev);
      exp_t e;
      e.beats = beats; e.frt = frt; e.lab_n = lab_n; e.lab_sum = lab_sum;
      e.nxt_pat = np; e.nxt_grp = ng; e.rst_ifm = ri; e.rst_ftr = rf;
      e.pool = pool; e.vcol = vc; e.vpsum = vp; e.even = ev;
      return e;
   endfunction

   // Monitor: accumulates what the DUT presents and compares against the scoreboard on done
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || abort) begin
         acc = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
         if (fetch_vld && fetch_rdy) begin
            acc.beats++;
            since_beat = 0;
            if (frt_act_row) acc.frt++;
            if (lst_act_blk) begin acc.lab_n++; acc.lab_sum += acc.beats; end
            if (pool_en)     acc.pool++;
            if (val_col)     acc.vcol++;
            if (val_psum)    acc.vpsum++;
            if (even_frm)    acc.even++;
         end else begin
            since_beat++;
         end
         if (nxt_pat) acc.nxt_pat++;
         if (nxt_grp) acc.nxt_grp++;
         if (rst_ifm) acc.rst_ifm++;
         if (rst_ftr) acc.rst_ftr++;
         if (done) begin
            done_seen++;
            chk("done_busy", int'(busy), 0);
            chk("done_fetch_vld", int'(fetch_vld), 0);
            chk("done_latency", since_beat, 1);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
               e = sb.pop_front();
               chk("beats", acc.beats, e.beats);
               chk("frt_act_row_n", acc.frt, e.frt);
               chk("lst_act_blk_n", acc.lab_n, e.lab_n);
               chk("lst_act_blk_pos", acc.lab_sum, e.lab_sum);
               chk("nxt_pat_n", acc.nxt_pat, e.nxt_pat);
               chk("nxt_grp_n", acc.nxt_grp, e.nxt_grp);
               chk("rst_ifm_n", acc.rst_ifm, e.rst_ifm);
               chk("rst_ftr_n", acc.rst_ftr, e.rst_ftr);
               chk("pool_en_n", acc.pool, e.pool);
               chk("val_col_n", acc.vcol, e.vcol);
               chk("val_psum_n", acc.vpsum, e.vpsum);
               chk("even_frm_n", acc.even, e.even);
            end
            acc = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         end
      end
   end

   task automatic set_cfg(input int len, blk, frm, pat, grp, inner);
      cfg_len_row   = 5'(len);
      cfg_num_blk   = 4'(blk);
      cfg_num_frm   = 4'(frm);
      cfg_num_pat   = 4'(pat);
      cfg_num_grp   = 4'(grp);
      cfg_pat_inner = inner[0];
   endtask

   task automatic run_layer(input string name, input int len, blk, frm, pat, grp, inner,
                            input bit rdy_toggle, input bit midrun, input exp_t e);
      int d0;
      set_cfg(len, blk, frm, pat, grp, inner);
      sb.push_back(e);
      d0 = done_seen;
      @(posedge clk); #1;
      start = 1'b1;
      fetch_rdy = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3000 && done_seen == d0; i++) begin
         fetch_rdy = rdy_toggle ? ~fetch_rdy : 1'b1;
         if (midrun && i == 4) begin
            start = 1'b1;
            set_cfg(5, 3, 2, 1, 1, ~inner);
         end
         if (midrun && i == 5) start = 1'b0;
         @(posedge clk); #1;
      end
      if (done_seen == d0) begin
         checks++;
         failures++;
         $display("FAIL %s timeout actual=no_done required=done", name);
      end
      fetch_rdy = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; fetch_rdy = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          int'({fetch_vld, frt_act_row, lst_act_row, lst_act_blk, frt_blk, val_col, val_psum,
                even_frm, pool_en, nxt_pat, nxt_grp, rst_ifm, rst_ftr, busy, done}), 0);
      chk("reset_cnt_pat", int'(cnt_pat), 0);
      chk("reset_cnt_grp", int'(cnt_grp), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // beats frt lab_n lab_sum np ng ri rf pool vcol vpsum even
      run_layer("t1_min",   2, 0, 0, 0, 0, 1, 1'b0, 1'b0, mk( 9,  3,  1,   9, 0, 0, 0, 0, 0,  3,  3,  9));
      run_layer("t2_stall", 3, 1, 0, 0, 0, 1, 1'b1, 1'b0, mk(32,  8,  2,  48, 0, 0, 0, 0, 0, 16, 16, 32));
      run_layer("t3_pin1",  1, 0, 1, 2, 1, 1, 1'b0, 1'b0, mk(48, 24, 12, 312, 4, 1, 1, 0, 0,  0,  0, 24));
      run_layer("t4_pin0",  1, 0, 1, 2, 1, 0, 1'b0, 1'b0, mk(48, 24, 12, 312, 2, 3, 0, 2, 0,  0,  0, 24));

      // Abort mid-run: one step is 4 beats, so beat 5 sees cnt_pat=1 and the nxt_pat pulse
      set_cfg(1, 0, 0, 7, 0, 1);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && n < 5; i++) begin
         @(negedge clk);
         if (fetch_vld && fetch_rdy) n++;
      end
      chk("t5_beats_before_abort", n, 5);
      chk("t5_cnt_pat_before", int'(cnt_pat), 1);
      chk("t5_nxt_pat_before", int'(nxt_pat), 1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("t5_fetch_vld_after", int'(fetch_vld), 0);
      chk("t5_busy_after", int'(busy), 0);
      chk("t5_cnt_pat_after", int'(cnt_pat), 0);
      chk("t5_lst_act_row_after", int'(lst_act_row), 0);
      run_layer("t5_restart", 1, 0, 0, 1, 0, 1, 1'b0, 1'b0, mk( 8,  4,  2,  12, 1, 0, 0, 0, 0,  0,  0,  8));

      run_layer("t6_midrun", 2, 1, 1, 0, 0, 1, 1'b0, 1'b1, mk(36, 12,  4,  90, 0, 0, 0, 0, 1, 12, 12, 18));

      @(negedge clk);
      chk("idle_after_layers", int'(busy), 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
